// File: rtl/conv_sched.sv
// Layer sequencer for the 9x18 MAC array: weight load, accumulate, drain, done.
// Phase codes on o_current_state: IDLE=000 LOAD_W=001 ACC=010 DRAIN=011 DONE=100.
module conv_sched #(
  parameter int IC_W                = 6,
  parameter int PIX_W               = 12,
  parameter int MULT_PIPELINE_STAGE = 2,
  parameter int ADDER_LAT           = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [IC_W-1:0]  i_cfg_ic_groups,
  input  logic [PIX_W-1:0] i_cfg_pixels,
  input  logic             i_stall,
  output logic             o_wgt_req,
  input  logic             i_wgt_ack,
  output logic [2:0]       o_current_state,
  output logic             o_state_rst,
  output logic             o_adder_rst,
  output logic             o_mac_en,
  output logic             o_out_valid,
  output logic [PIX_W-1:0] o_pix_idx,
  output logic             o_busy,
  output logic             o_done
);

  localparam int LAT = MULT_PIPELINE_STAGE + ADDER_LAT;
  localparam int DW  = $clog2(LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_LOAD_W = 3'b001,
    S_ACC    = 3'b010,
    S_DRAIN  = 3'b011,
    S_DONE   = 3'b100
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IC_W-1:0]  r_cfg_ic;
  logic [PIX_W-1:0] r_cfg_pix;
  logic [IC_W-1:0]  r_g;
  logic [PIX_W-1:0] r_p;
  logic [DW-1:0]    r_drain_cnt;
  logic [LAT-1:0]   r_vld;
  logic [PIX_W-1:0] r_pix [LAT];
  logic             r_state_rst;

  logic w_abort;
  logic w_issue;
  logic w_grp_last;
  logic w_pix_last;

  assign w_abort    = i_abort && (r_state != S_IDLE);
  assign w_grp_last = (r_g == r_cfg_ic);
  assign w_pix_last = (r_p == r_cfg_pix);

  // Abort wins over every transition and suppresses this cycle's strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (i_wgt_ack) w_state_nxt = S_ACC;
      end
      S_ACC: begin
        if (!i_stall) begin
          w_issue = 1'b1;
          if (w_grp_last && w_pix_last) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_abort) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_state_rst <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_state_rst <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg_ic  <= '0;
      r_cfg_pix <= '0;
    end else if (r_state == S_IDLE && i_start) begin
      r_cfg_ic  <= i_cfg_ic_groups;
      r_cfg_pix <= i_cfg_pixels;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_g <= '0;
      r_p <= '0;
    end else if (w_abort || r_state != S_ACC) begin
      r_g <= '0;
      r_p <= '0;
    end else if (w_issue) begin
      if (w_grp_last) begin
        r_g <= '0;
        r_p <= r_p + 1'b1;
      end else begin
        r_g <= r_g + 1'b1;
      end
    end
  end

  // Drain length equals LAT so the final result lands in the last DRAIN cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drain_cnt <= '0;
    end else if (w_abort) begin
      r_drain_cnt <= '0;
    end else if (r_state == S_ACC && w_state_nxt == S_DRAIN) begin
      r_drain_cnt <= DW'(LAT - 1);
    end else if (r_state == S_DRAIN && r_drain_cnt != '0) begin
      r_drain_cnt <= r_drain_cnt - 1'b1;
    end
  end

  // Result delay line keeps shifting through stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_pix[i] <= '0;
    end else if (w_abort) begin
      r_vld <= '0;
      for (int i = 0; i < LAT; i++) r_pix[i] <= '0;
    end else begin
      r_vld[0] <= w_issue && w_grp_last;
      r_pix[0] <= r_p;
      for (int i = 1; i < LAT; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_pix[i] <= r_pix[i-1];
      end
    end
  end

  assign o_current_state = r_state;
  assign o_busy          = (r_state != S_IDLE);
  assign o_wgt_req       = (r_state == S_LOAD_W);
  assign o_mac_en        = w_issue;
  assign o_adder_rst     = w_issue && (r_g == '0);
  assign o_out_valid     = r_vld[LAT-1] && !w_abort;
  assign o_pix_idx       = r_pix[LAT-1];
  assign o_done          = (r_state == S_DONE) && !w_abort;
  assign o_state_rst     = r_state_rst;

endmodule

// File: tb/tb_conv_sched.sv
// Randomized bench for conv_sched: an event-timeline model feeds scoreboard queues
// that a negedge monitor drains against the DUT strobes.
module tb_conv_sched;
  localparam int IC_W  = 6;
  localparam int PIX_W = 12;
  localparam int LAT   = 5;

  logic             clk = 1'b0;
  logic             rst, start, abort, stall, wgt_ack;
  logic [IC_W-1:0]  cfg_ic;
  logic [PIX_W-1:0] cfg_pix;
  logic             wgt_req, state_rst, adder_rst, mac_en, out_valid, busy, done;
  logic [2:0]       cur_state;
  logic [PIX_W-1:0] pix_idx;

  conv_sched #(.IC_W(IC_W), .PIX_W(PIX_W), .MULT_PIPELINE_STAGE(2), .ADDER_LAT(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_cfg_ic_groups(cfg_ic), .i_cfg_pixels(cfg_pix), .i_stall(stall),
    .o_wgt_req(wgt_req), .i_wgt_ack(wgt_ack), .o_current_state(cur_state),
    .o_state_rst(state_rst), .o_adder_rst(adder_rst), .o_mac_en(mac_en),
    .o_out_valid(out_valid), .o_pix_idx(pix_idx), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {int c; int v;} ev_t;
  ev_t q_mac[$];
  ev_t q_ov[$];
  int  q_done[$];
  int  q_srst[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endfunction

  // Monitor: every expected strobe must appear on its cycle; any other strobe is unexpected.
  always @(negedge clk) begin
    if (q_mac.size() > 0 && q_mac[0].c == cyc) begin
      chk("mac_en", int'(mac_en), 1);
      chk("adder_rst", int'(adder_rst), q_mac[0].v);
      void'(q_mac.pop_front());
    end else begin
      if (mac_en) chk("mac_en_unexpected", int'(mac_en), 0);
      if (adder_rst) chk("adder_rst_unexpected", int'(adder_rst), 0);
    end
    if (q_ov.size() > 0 && q_ov[0].c == cyc) begin
      chk("out_valid", int'(out_valid), 1);
      chk("pix_idx", int'(pix_idx), q_ov[0].v);
      void'(q_ov.pop_front());
    end else if (out_valid) begin
      chk("out_valid_unexpected", int'(out_valid), 0);
    end
    if (q_done.size() > 0 && q_done[0] == cyc) begin
      chk("done", int'(done), 1);
      void'(q_done.pop_front());
    end else if (done) begin
      chk("done_unexpected", int'(done), 0);
    end
    if (q_srst.size() > 0 && q_srst[0] == cyc) begin
      chk("state_rst", int'(state_rst), 1);
      void'(q_srst.pop_front());
    end else if (state_rst) begin
      chk("state_rst_unexpected", int'(state_rst), 0);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start   = 1'b0;
      wgt_ack = ($urandom_range(0, 3) == 0);
      stall   = ($urandom_range(0, 3) == 0);
      abort   = ($urandom_range(0, 3) == 0);
      cfg_ic  = IC_W'($urandom);
      cfg_pix = PIX_W'($urandom);
      @(negedge clk);
      chk("idle_state", int'(cur_state), 0);
      chk("idle_busy", int'(busy), 0);
      @(posedge clk); #1;
    end
  endtask

  // mode: 0 clean, 1 abort at last_issue+kk, 2 abort at random cycle, 3 rst at acc_start+kk
  task automatic run_layer(input int g, input int p, input int d, input int st_off,
                           input int st_len, input int mode, input int kk);
    int S, A, n, c, cL, K, last, done_c, ph;
    int iss[$];
    logic rst_now;
    S = cyc;
    A = S + 2 + d;
    n = (g + 1) * (p + 1);
    c = A;
    while (iss.size() < n) begin
      if (!(st_len > 0 && c >= A + st_off && c < A + st_off + st_len)) iss.push_back(c);
      c++;
    end
    cL = iss[n-1];
    done_c = cL + LAT + 1;
    K = 1 << 30;
    if (mode == 1) K = cL + kk;
    else if (mode == 2) K = S + 1 + int'($urandom_range(0, done_c - S - 1));
    else if (mode == 3) K = A + kk;
    for (int k = 0; k < n; k++) begin
      if (iss[k] < K) q_mac.push_back('{iss[k], int'(k % (g + 1) == 0)});
      if (k % (g + 1) == g && iss[k] + LAT < K) q_ov.push_back('{iss[k] + LAT, k / (g + 1)});
    end
    if (done_c < K) q_done.push_back(done_c);
    if (mode == 3) last = K + 2;
    else if (K <= done_c) begin q_srst.push_back(K + 1); last = K + 1; end
    else begin q_srst.push_back(done_c + 1); last = done_c + 1; end

    for (c = S; c <= last; c++) begin
      if (mode == 3 && c >= K) ph = 0;
      else if (mode != 3 && c > K) ph = 0;
      else if (c <= S) ph = 0;
      else if (c < A) ph = 1;
      else if (c <= cL) ph = 2;
      else if (c < done_c) ph = 3;
      else if (c == done_c) ph = 4;
      else ph = 0;
      rst_now = (mode == 3) && (c == K || c == K + 1);
      rst     = rst_now;
      start   = (c == S) || (ph != 0 && !rst_now && $urandom_range(0, 3) == 0);
      if (c == S + 1 + d) wgt_ack = 1'b1;
      else wgt_ack = (ph != 1) && ($urandom_range(0, 3) == 0);
      if (ph == 2) stall = (st_len > 0 && c >= A + st_off && c < A + st_off + st_len);
      else stall = ($urandom_range(0, 2) == 0);
      abort = ((mode == 1 || mode == 2) && c == K) ||
              (ph == 0 && !rst_now && $urandom_range(0, 7) == 0);
      if (c == S) begin
        cfg_ic  = IC_W'(g);
        cfg_pix = PIX_W'(p);
      end else begin
        cfg_ic  = IC_W'($urandom);
        cfg_pix = PIX_W'($urandom);
      end
      @(negedge clk);
      chk("current_state", int'(cur_state), ph);
      chk("busy", int'(busy), int'(ph != 0));
      chk("wgt_req", int'(wgt_req), int'(ph == 1));
      if (rst_now) chk("pix_idx_in_rst", int'(pix_idx), 0);
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; stall = 1'b0; wgt_ack = 1'b0; rst = 1'b0;
  endtask

  initial begin
    int g, p, r, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0; wgt_ack = 1'b0;
    cfg_ic = '0; cfg_pix = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", int'(cur_state), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_mac_en", int'(mac_en), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_state_rst", int'(state_rst), 0);
    chk("rst_wgt_req", int'(wgt_req), 0);
    chk("rst_pix_idx", int'(pix_idx), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    run_layer(2, 3, 4, 0, 0, 0, 0);
    idle(2);
    run_layer(2, 3, 4, 4, 3, 0, 0);
    idle(2);
    run_layer(0, 0, 1, 0, 0, 0, 0);
    idle(2);
    run_layer(1, 3, 2, 0, 0, 1, 2);
    idle(2);
    run_layer(2, 3, 1, 0, 0, 3, 5);
    idle(2);
    run_layer(2, 3, 0, 0, 0, 0, 0);
    idle(2);

    for (int t = 0; t < 30; t++) begin
      g = int'($urandom_range(0, 3));
      p = int'($urandom_range(0, 5));
      n = (g + 1) * (p + 1);
      r = int'($urandom_range(0, 9));
      if (r <= 5)
        run_layer(g, p, int'($urandom_range(0, 5)), int'($urandom_range(0, n)),
                  int'($urandom_range(0, 3)), 0, 0);
      else if (r <= 7)
        run_layer(g, p, int'($urandom_range(0, 5)), int'($urandom_range(0, n)),
                  int'($urandom_range(0, 3)), 2, 0);
      else if (r == 8)
        run_layer(g, p, int'($urandom_range(0, 5)), int'($urandom_range(0, n)),
                  int'($urandom_range(0, 3)), 1, int'($urandom_range(1, LAT)));
      else
        run_layer(g, p, int'($urandom_range(0, 5)), int'($urandom_range(0, n)),
                  int'($urandom_range(0, 3)), 3, int'($urandom_range(0, n - 1)));
      idle(int'($urandom_range(1, 3)));
    end

    idle(8);
    chk("q_mac_left", q_mac.size(), 0);
    chk("q_ov_left", q_ov.size(), 0);
    chk("q_done_left", q_done.size(), 0);
    chk("q_srst_left", q_srst.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conv_sched.md
Name: conv_sched

Overview:
- Top-level sequencer for the convolution unit (9-input x 18-output MAC array).
- Steps through four phases: weight load, accumulation over pixels and input-channel groups, pipeline drain, done.
- Drives the phase code consumed by the conv control decoder: INIT=000, A=001, B=010, C=011, DONE=100.
- Generates the accumulator reset, MAC enable and output-valid strobes, so the MAC array and adder tree run without a host in the loop.

Parameters:
- IC_W, 6: width of the input-channel-group count (groups of 9 channels).
- PIX_W, 12: width of the output-pixel count.
- MULT_PIPELINE_STAGE, 2: multiplier pipeline depth in cycles.
- ADDER_LAT, 3: adder-tree latency in cycles.
- LAT, MULT_PIPELINE_STAGE+ADDER_LAT: mac_en-to-result latency (derived, not overridable).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  start a layer; sampled in IDLE only.
- abort  in  1  synchronous abort; any state returns to IDLE.
- cfg_ic_groups  in  IC_W  channel groups minus 1; latched on start.
- cfg_pixels  in  PIX_W  output pixels minus 1; latched on start.
- stall  in  1  freezes the accumulation counters.
- wgt_req  out  1  weight-load request.
- wgt_ack  in  1  weight load complete (1-cycle pulse).
- current_state  out  3  phase code.
- state_rst  out  1  1-cycle pulse on return to IDLE.
- adder_rst  out  1  clear the accumulators (first group of each pixel).
- mac_en  out  1  MAC array issue enable.
- out_valid  out  1  accumulated pixel result valid.
- pix_idx  out  PIX_W  index of the pixel on out_valid.
- busy  out  1  high whenever not in IDLE.
- done  out  1  1-cycle pulse at layer end.

Behaviour:
Reset (rst high, asynchronous):
- State IDLE; all counters, delay lines and outputs 0.
- current_state=000.

State machine:
- IDLE (000): start=1 latches cfg_*, goes to LOAD_W next cycle. busy=0.
- LOAD_W (001):
  - wgt_req=1 from the entry cycle onward.
  - wgt_ack=1 -> ACC next cycle; wgt_req drops in that ACC cycle.
  - wgt_ack outside LOAD_W is ignored.
- ACC (010):
  - Counters g (group) and p (pixel) start at 0.
  - Each non-stalled cycle: mac_en=1, adder_rst=(g==0).
  - g increments; at g==cfg_ic_groups, g wraps to 0 and p increments.
  - Last issue (g==cfg_ic_groups and p==cfg_pixels) -> DRAIN next cycle.
  - stall=1: mac_en=0, adder_rst=0, counters hold. stall is ignored outside ACC.
- DRAIN (011): wait LAT cycles with a counter, then -> DONE.
- DONE (100): done=1 for one cycle, then -> IDLE with state_rst=1 in the first IDLE cycle.
- abort=1 in any non-IDLE state:
  - IDLE next cycle; counters and the delay line are cleared.
  - state_rst=1 in the first IDLE cycle; done stays 0; pending out_valid pulses are discarded.
- abort has priority over every transition. abort in IDLE has no effect. start outside IDLE is ignored.

Output-valid timing:
- The last-group issue (mac_en=1 with g==cfg_ic_groups) enters a LAT-deep delay line together with p.
- out_valid=1 exactly LAT cycles after that issue, with pix_idx=p.
- The delay line always shifts; stall does not freeze it.
- The final out_valid falls in the last DRAIN cycle, so DONE follows it by one cycle.

Boundary cases:
- cfg_ic_groups=0: adder_rst=1 on every issue, one out_valid per issue cycle.
- cfg_pixels=0: one pixel only.
- Counters wrap at cfg values, never at 2^W.
- Issue count per layer = (cfg_ic_groups+1)*(cfg_pixels+1).

Test Plan:
- Reset mid-ACC (rst for 2 cycles) -> current_state=000, all outputs 0 immediately; start afterwards begins a clean run.
- cfg_ic_groups=2, cfg_pixels=3, wgt_ack 4 cycles after wgt_req, no stall:
  - 12 mac_en cycles; adder_rst on issues 0,3,6,9.
  - out_valid with pix_idx 0..3, each 5 cycles after issues 2,5,8,11.
  - done once; state_rst once.
- Same config with stall=1 for 3 cycles at issue 4 -> mac_en gap of 3 cycles, still 12 issues; out_valid spacing shifted by 3; pix_idx order unchanged.
- cfg_ic_groups=0, cfg_pixels=0 -> one mac_en with adder_rst=1; out_valid 5 cycles later with pix_idx=0; then DONE, then IDLE.
- abort during DRAIN with 2 results pending -> IDLE next cycle, state_rst=1, no further out_valid, done never asserted.
- start during ACC and wgt_ack in IDLE -> no effect on state, counters or outputs.
